// File: rtl/atm_light_stream.sv
// atm_light_stream: frame-level atmospheric light estimator.
// Tracks the brightest dark-channel pixel per frame, optionally IIR-smooths
// the result across frames, then derives per-channel reciprocals with a
// serial restoring divider (one quotient bit per cycle, one channel at a time).
module atm_light_stream #(
    parameter int DW        = 8,
    parameter int NCH       = 3,
    parameter int INV_W     = 16,
    parameter int SMOOTH_SH = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pix_valid,
    input  logic                 pix_sof,
    input  logic                 pix_eof,
    input  logic [NCH*DW-1:0]    pix_data,
    output logic [NCH*DW-1:0]    a_out,
    output logic [NCH*INV_W-1:0] inv_out,
    output logic [DW-1:0]        dark_max,
    output logic                 a_valid,
    output logic                 busy,
    output logic                 frame_err
);
    localparam int QW = 2*DW + 1;                  // quotient bits of 2^(2*DW)/A
    localparam int WW = (QW > INV_W) ? QW : INV_W;
    localparam int BW = $clog2(QW);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [63:0] INV_RST_FULL = (64'd1 << (2*DW)) / ((64'd1 << DW) - 64'd1);
    localparam logic [INV_W-1:0] INV_RST =
        (INV_RST_FULL >= (64'd1 << INV_W)) ? {INV_W{1'b1}} : INV_RST_FULL[INV_W-1:0];

    typedef enum logic [1:0] {S_IDLE, S_SMOOTH, S_DIV, S_DONE} state_t;
    state_t r_state, w_state_nx;

    logic                 r_in_frame;
    logic [NCH*DW-1:0]    r_cand;
    logic [DW-1:0]        r_cand_d;
    logic [NCH*DW-1:0]    r_af;          // accepted frame's candidate colour
    logic [DW-1:0]        r_df;          // accepted frame's dark maximum
    logic [NCH*DW-1:0]    r_as;          // smoothed A used by the divider
    logic                 r_first;
    logic [DW:0]          r_rem;
    logic [QW-1:0]        r_q;
    logic [BW-1:0]        r_bit;
    logic [CW-1:0]        r_ch;
    logic [NCH*INV_W-1:0] r_inv;
    logic [NCH*DW-1:0]    r_a_out;
    logic [NCH*INV_W-1:0] r_inv_out;
    logic [DW-1:0]        r_dark_max;
    logic                 r_a_valid;
    logic                 r_frame_err;

    logic [DW-1:0]        w_d;
    logic                 w_hit, w_take, w_eof, w_accept, w_drop, w_sof_err, w_last;
    logic [NCH*DW-1:0]    w_fin;
    logic [DW-1:0]        w_fin_d;
    logic [NCH*DW-1:0]    w_smooth;
    logic [DW-1:0]        w_div;
    logic [DW+1:0]        w_rem_sh, w_rem_nx;
    logic                 w_ge;
    logic [QW-1:0]        w_q_nx;
    logic [WW-1:0]        w_qw;
    logic [INV_W-1:0]     w_sat;

    // Dark value of the incoming pixel: minimum over colour channels
    always_comb begin
        w_d = pix_data[DW-1:0];
        for (int c = 1; c < NCH; c++)
            if (pix_data[c*DW +: DW] < w_d) w_d = pix_data[c*DW +: DW];
    end

    // A pixel counts if it opens a frame or lands inside one; strict > keeps
    // the first pixel in raster order on ties
    assign w_hit     = pix_valid & (pix_sof | r_in_frame);
    assign w_take    = pix_sof | (w_d > r_cand_d);
    assign w_fin     = w_take ? pix_data : r_cand;
    assign w_fin_d   = w_take ? w_d : r_cand_d;
    assign w_eof     = w_hit & pix_eof;
    assign w_accept  = w_eof & (r_state == S_IDLE);
    assign w_drop    = w_eof & (r_state != S_IDLE);
    assign w_sof_err = pix_valid & pix_sof & r_in_frame;
    assign w_last    = (r_ch == CW'(NCH-1)) && (r_bit == BW'(QW-1));

    // Per-channel IIR step in signed arithmetic wide enough for the difference
    for (genvar c = 0; c < NCH; c++) begin : g_smooth
        logic signed [DW+1:0] w_diff, w_sum;
        assign w_diff = $signed({2'b00, r_af[c*DW +: DW]}) - $signed({2'b00, r_as[c*DW +: DW]});
        assign w_sum  = $signed({2'b00, r_as[c*DW +: DW]}) + (w_diff >>> SMOOTH_SH);
        assign w_smooth[c*DW +: DW] = w_sum[DW-1:0];
    end

    // One restoring-divide step; the dividend is a single 1 followed by zeros
    always_comb begin
        w_div    = r_as[int'(r_ch)*DW +: DW];
        w_rem_sh = {r_rem, (r_bit == '0)};
        w_ge     = (w_rem_sh >= {2'b00, w_div});
        w_rem_nx = w_ge ? (w_rem_sh - {2'b00, w_div}) : w_rem_sh;
        w_q_nx   = {r_q[QW-2:0], w_ge};
        w_qw     = WW'(w_q_nx);
        w_sat    = ((w_div == '0) || ((w_qw >> INV_W) != '0)) ? {INV_W{1'b1}} : w_qw[INV_W-1:0];
    end

    // Frame accumulator runs regardless of divider activity
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_frame <= 1'b0;
            r_cand     <= '0;
            r_cand_d   <= '0;
        end else if (w_hit) begin
            r_cand     <= w_fin;
            r_cand_d   <= w_fin_d;
            r_in_frame <= ~pix_eof;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nx;
    end

    // FSM next state
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_state_nx = S_SMOOTH;
            S_SMOOTH: w_state_nx = S_DIV;
            S_DIV:    if (w_last) w_state_nx = S_DONE;
            S_DONE:   w_state_nx = S_IDLE;
            default:  w_state_nx = S_IDLE;
        endcase
    end

    // Hand-off, smoothing, divider and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_af        <= '0;
            r_df        <= '0;
            r_as        <= '1;
            r_first     <= 1'b1;
            r_rem       <= '0;
            r_q         <= '0;
            r_bit       <= '0;
            r_ch        <= '0;
            r_inv       <= {NCH{INV_RST}};
            r_a_out     <= '1;
            r_inv_out   <= {NCH{INV_RST}};
            r_dark_max  <= '0;
            r_a_valid   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_a_valid   <= 1'b0;
            r_frame_err <= w_drop | w_sof_err;
            if (w_accept) begin
                r_af <= w_fin;
                r_df <= w_fin_d;
            end
            case (r_state)
                S_SMOOTH: begin
                    r_as    <= r_first ? r_af : w_smooth;
                    r_first <= 1'b0;
                    r_rem   <= '0;
                    r_q     <= '0;
                    r_bit   <= '0;
                    r_ch    <= '0;
                end
                S_DIV: begin
                    if (r_bit == BW'(QW-1)) begin
                        r_inv[int'(r_ch)*INV_W +: INV_W] <= w_sat;
                        r_rem <= '0;
                        r_q   <= '0;
                        r_bit <= '0;
                        r_ch  <= w_last ? '0 : r_ch + 1'b1;
                    end else begin
                        r_rem <= w_rem_nx[DW:0];
                        r_q   <= w_q_nx;
                        r_bit <= r_bit + 1'b1;
                    end
                end
                S_DONE: begin
                    r_a_out    <= r_as;
                    r_inv_out  <= r_inv;
                    r_dark_max <= r_df;
                    r_a_valid  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign a_out     = r_a_out;
    assign inv_out   = r_inv_out;
    assign dark_max  = r_dark_max;
    assign a_valid   = r_a_valid;
    assign busy      = (r_state != S_IDLE);
    assign frame_err = r_frame_err;

endmodule

// File: doc/atm_light_stream.md
# atm_light_stream

Frame-level atmospheric-light estimator for the dehazing pipeline, the parametrised successor of the 3×3-window atmospheric light block. It consumes a raster pixel stream, tracks the pixel whose dark channel (min over colour channels) is largest over the whole frame, and latches that pixel's colour as A at end of frame. It optionally smooths A across frames and then computes the per-channel reciprocal with an iterative divider. A and its inverse feed the transmission and recovery stages.

## Interface
- DW, 8, bits per colour channel
- NCH, 3, colour channels; channel 0 in LSBs
- INV_W, 16, width of each reciprocal
- SMOOTH_SH, 0, IIR shift for temporal smoothing of A; 0 = no smoothing

- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- pix_valid  in  1  pixel qualifier; always accepted, no backpressure
- pix_sof  in  1  first pixel of frame; meaningful only with pix_valid
- pix_eof  in  1  last pixel of frame; meaningful only with pix_valid
- pix_data  in  NCH*DW  pixel colour
- a_out  out  NCH*DW  atmospheric light per channel
- inv_out  out  NCH*INV_W  floor(2^(2*DW) / A_c) per channel, saturated
- dark_max  out  DW  largest dark-channel value of the last completed frame
- a_valid  out  1  one-cycle pulse when a_out, inv_out and dark_max update
- busy  out  1  smoothing/divide in progress
- frame_err  out  1  one-cycle pulse on protocol error or dropped frame

## Operation
- Dark value per pixel: d = min over c of pix_data[c].
- Accumulator, active while in_frame:
  - sof pixel loads cand = pixel, cand_d = d, and sets in_frame.
  - Each later valid pixel replaces cand only if d > cand_d (strict). On ties, the first pixel in raster order wins.
  - eof pixel is evaluated, then ends the frame and clears in_frame.
  - sof and eof on the same pixel form a valid one-pixel frame.
- Valid pixels with in_frame low and no sof are ignored.
- sof while in_frame: the partial frame is discarded, accumulation restarts at this pixel, and frame_err pulses.
- At eof the final cand/cand_d is handed to the FSM. If busy is high, the frame is dropped, frame_err pulses, and nothing else changes. Accumulation runs independently of the FSM, so the next frame's pixels may arrive while busy.
- FSM: IDLE -> SMOOTH (1 cycle) -> DIV (NCH*(2*DW+1) cycles) -> DONE (1 cycle) -> IDLE. busy is high in SMOOTH, DIV and DONE.
- SMOOTH, per channel, signed DW+1 arithmetic: A_s <= A_s + ((A_f - A_s) >>> SMOOTH_SH). On the first accepted frame after reset, A_s <= A_f directly.
- DIV: restoring divider, one channel at a time from channel 0, one quotient bit per cycle, 2*DW+1 bits of 2^(2*DW)/A_s.
  - If A_s = 0, or the quotient is ≥ 2^INV_W, the result is 2^INV_W-1.
- DONE:
  - a_out <= A_s; inv_out <= quotients; dark_max <= frame cand_d.
  - a_valid pulses.
  - Outputs stay stable between a_valid pulses.

## Timing
- Reset values:
  - a_out = all ones per channel.
  - inv_out = floor(2^(2*DW)/(2^DW-1)) per channel, which is 257 for the defaults.
  - dark_max = 0.
  - a_valid = busy = frame_err = 0.
  - FSM IDLE, in_frame = 0, first-frame flag set.
- Latency: eof pixel sampled at edge k -> a_valid high in the cycle after edge k+L, with L = NCH*(2*DW+1)+2. Defaults: L = 53.
- busy rises the cycle after the eof edge and falls with a_valid.
- An eof that arrives when busy is already low (including the cycle after a_valid) is accepted.
- frame_err pulses in the cycle after the offending edge.
- rst mid-frame or mid-divide:
  - All state and outputs return to reset values next edge.
  - No a_valid for the aborted frame.
  - The next frame after reset is treated as the first frame.

## Test plan
- Uniform 4×4 frame, all pixels (R,G,B) = (100,120,140), defaults -> a_out = (100,120,140), inv_out = (655,546,468), dark_max = 100, a_valid exactly 53 cycles after the eof cycle.
- 9-pixel frame with R = 50,200,150,180,90,220,130,60,110; G = 10,210,170,190,80,200,140,40,120; B = 90,180,160,200,70,230,120,50,140 -> a_out = (220,200,230), inv_out = (297,327,284), dark_max = 200.
- Tie and single-pixel frames:
  - 2-pixel frame (200,210,180) then (180,190,200) -> a_out = (200,210,180).
  - Single-pixel frame with sof and eof both set, pixel (0,0,0) -> inv_out = (65535,65535,65535).
- SMOOTH_SH = 2: uniform frame A = 100 then uniform frame A = 200 -> a_out = 100 after the first frame and 125 after the second. Third frame A = 200 -> 143.
- Protocol errors:
  - Second frame's eof arrives 10 cycles after the first eof -> frame_err pulses once; only one a_valid, carrying the first frame's result.
  - sof mid-frame -> frame_err pulses; the result reflects only the pixels from the new sof onward.
- Reset: assert rst during DIV -> next cycle all outputs at reset values, busy 0, no a_valid. A following frame is loaded directly, without smoothing.
